// File: rtl/ysyx_idu_queue.sv
// ysyx_idu_queue: fetch-to-decode FIFO holding {pc, inst} pairs.
// The head entry is decoded combinationally into RV32I fields, the
// format class, the sign-extended immediate and an illegal flag.
// A flush from fetch empties the queue in a single cycle.
module ysyx_idu_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] pc,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic              flush,
  input  logic              next_ready,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SYS  = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_inst;

  // Format class from opcode; anything without the 2'b11 low bits is not RV32I.
  function automatic logic [2:0] decode_fmt(input logic [6:0] op);
    logic [2:0] f;
    f = FMT_NONE;
    if (op[1:0] == 2'b11) begin
      case (op)
        7'b0110011:                         f = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
        7'b0100011:                         f = FMT_S;
        7'b1100011:                         f = FMT_B;
        7'b0110111, 7'b0010111:             f = FMT_U;
        7'b1101111:                         f = FMT_J;
        7'b1110011, 7'b0001111:             f = FMT_SYS;
        default:                            f = FMT_NONE;
      endcase
    end
    return f;
  endfunction

  // Immediate assembly; sign comes from bit 31 except U and SYS/FENCE.
  function automatic logic signed [DATA_W-1:0] gen_imm(input logic [DATA_W-1:0] ins,
                                                       input logic [2:0]        f);
    logic signed [DATA_W-1:0] v;
    logic                     s;
    s = ins[31];
    case (f)
      FMT_I:   v = $signed({{(DATA_W-12){s}}, ins[31:20]});
      FMT_S:   v = $signed({{(DATA_W-12){s}}, ins[31:25], ins[11:7]});
      FMT_B:   v = $signed({{(DATA_W-13){s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      FMT_U:   v = $signed(DATA_W'({ins[31:12], 12'b0}));
      FMT_J:   v = $signed({{(DATA_W-21){s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      FMT_SYS: v = $signed(DATA_W'(ins[31:20]));
      default: v = '0;
    endcase
    return v;
  endfunction

  assign ready_o = (count != CNT_W'(DEPTH));
  assign valid_o = (count != '0);
  assign push    = prev_valid & ready_o;
  assign pop     = valid_o & next_ready;

  // Queue control: pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: cleared on reset so the idle head decodes all-zero; flushed pushes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= inst;
    end
  end

  assign head_inst = inst_mem[rd_ptr];

  // Head decode: purely from stored state, so no input reaches an output combinationally.
  always_comb begin
    pc_o      = pc_mem[rd_ptr];
    inst_o    = head_inst;
    opcode_o  = head_inst[6:0];
    rd_o      = head_inst[11:7];
    rs1_o     = head_inst[19:15];
    rs2_o     = head_inst[24:20];
    funct3_o  = head_inst[14:12];
    funct7_o  = head_inst[31:25];
    fmt_o     = decode_fmt(head_inst[6:0]);
    imm_o     = $unsigned(gen_imm(head_inst, fmt_o));
    illegal_o = (fmt_o == FMT_NONE);
  end

endmodule

// File: tb/tb_ysyx_idu_queue.sv
// Directed bench for ysyx_idu_queue: decode vectors, backpressure,
// flush, reset mid-operation and pointer wrap under push+pop.
module tb_ysyx_idu_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        prev_valid;
  logic        ready_o;
  logic        flush;
  logic        next_ready;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  ysyx_idu_queue #(.DATA_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .pc         (pc),
    .prev_valid (prev_valid),
    .ready_o    (ready_o),
    .flush      (flush),
    .next_ready (next_ready),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .opcode_o   (opcode_o),
    .rd_o       (rd_o),
    .rs1_o      (rs1_o),
    .rs2_o      (rs2_o),
    .funct3_o   (funct3_o),
    .funct7_o   (funct7_o),
    .imm_o      (imm_o),
    .fmt_o      (fmt_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction with the consumer ready, check the decoded head, then confirm it popped.
  task automatic dec_case(input string tag, input logic [31:0] p, input logic [31:0] i,
                          input logic [2:0] f, input logic [31:0] im, input logic il,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] iv;
    iv         = i;
    prev_valid = 1'b1;
    pc         = p;
    inst       = i;
    next_ready = 1'b1;
    step();
    prev_valid = 1'b0;
    check_eq({tag, ".valid"},   32'(valid_o),   32'd1);
    check_eq({tag, ".pc"},      pc_o,           p);
    check_eq({tag, ".inst"},    inst_o,         i);
    check_eq({tag, ".opcode"},  32'(opcode_o),  32'(iv[6:0]));
    check_eq({tag, ".fmt"},     32'(fmt_o),     32'(f));
    check_eq({tag, ".imm"},     imm_o,          im);
    check_eq({tag, ".illegal"}, 32'(illegal_o), 32'(il));
    check_eq({tag, ".rd"},      32'(rd_o),      32'(rd));
    check_eq({tag, ".rs1"},     32'(rs1_o),     32'(rs1));
    check_eq({tag, ".rs2"},     32'(rs2_o),     32'(rs2));
    check_eq({tag, ".funct3"},  32'(funct3_o),  32'(f3));
    check_eq({tag, ".funct7"},  32'(funct7_o),  32'(f7));
    step();
    check_eq({tag, ".popped"},  32'(valid_o),   32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    inst       = '0;
    pc         = '0;
    prev_valid = 1'b0;
    flush      = 1'b0;
    next_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state: empty, ready, zero storage decodes as illegal
    check_eq("rst.valid",   32'(valid_o),   32'd0);
    check_eq("rst.ready",   32'(ready_o),   32'd1);
    check_eq("rst.pc",      pc_o,           32'h0);
    check_eq("rst.inst",    inst_o,         32'h0);
    check_eq("rst.fmt",     32'(fmt_o),     32'd7);
    check_eq("rst.imm",     imm_o,          32'h0);
    check_eq("rst.illegal", 32'(illegal_o), 32'd1);

    // Decode vectors: tag, pc, inst, fmt, imm, illegal, rd, rs1, rs2, funct3, funct7
    dec_case("addi",  32'h3000_0000, 32'h0050_0093, 3'd1, 32'h0000_0005, 1'b0, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00);
    dec_case("addim", 32'h3000_0004, 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF, 1'b0, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F);
    dec_case("beq",   32'h3000_0008, 32'hFE00_0EE3, 3'd3, 32'hFFFF_FFFC, 1'b0, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F);
    dec_case("jal",   32'h3000_000C, 32'h0080_00EF, 3'd5, 32'h0000_0008, 1'b0, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00);
    dec_case("lui",   32'h3000_0010, 32'h1234_5037, 3'd4, 32'h1234_5000, 1'b0, 5'd0,  5'd8, 5'd3,  3'd5, 7'h09);
    dec_case("zero",  32'h3000_0014, 32'h0000_0000, 3'd7, 32'h0000_0000, 1'b1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00);
    dec_case("sw",    32'h3000_0018, 32'h0020_A423, 3'd2, 32'h0000_0008, 1'b0, 5'd8,  5'd1, 5'd2,  3'd2, 7'h00);
    dec_case("add",   32'h3000_001C, 32'h0020_81B3, 3'd0, 32'h0000_0000, 1'b0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00);
    dec_case("csrr",  32'h3000_0020, 32'hC000_2573, 3'd6, 32'h0000_0C00, 1'b0, 5'd10, 5'd0, 5'd0,  3'd2, 7'h60);
    dec_case("lsb00", 32'h3000_0024, 32'h0050_0090, 3'd7, 32'h0000_0000, 1'b1, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00);
    dec_case("jalr",  32'h3000_0028, 32'h0000_80E7, 3'd1, 32'h0000_0000, 1'b0, 5'd1,  5'd1, 5'd0,  3'd0, 7'h00);

    // Backpressure: fill to two, third held by fetch, then drain in order
    next_ready = 1'b0;
    prev_valid = 1'b1;
    inst       = 32'h0000_0013;
    pc         = 32'h4000_0000;
    step();
    check_eq("bp.valid1", 32'(valid_o), 32'd1);
    check_eq("bp.ready1", 32'(ready_o), 32'd1);
    check_eq("bp.head1",  pc_o,         32'h4000_0000);
    pc = 32'h4000_0004;
    step();
    check_eq("bp.ready2", 32'(ready_o), 32'd0);
    check_eq("bp.head2",  pc_o,         32'h4000_0000);
    pc = 32'h4000_0008;
    step();
    check_eq("bp.ready3", 32'(ready_o), 32'd0);
    check_eq("bp.stable", pc_o,         32'h4000_0000);
    next_ready = 1'b1;
    step();
    check_eq("bp.headB",  pc_o,         32'h4000_0004);
    check_eq("bp.readyB", 32'(ready_o), 32'd1);
    step();
    prev_valid = 1'b0;
    check_eq("bp.headC",  pc_o,         32'h4000_0008);
    check_eq("bp.validC", 32'(valid_o), 32'd1);
    step();
    check_eq("bp.empty",  32'(valid_o), 32'd0);

    // Flush while full with a push presented: everything, including that push, disappears
    next_ready = 1'b0;
    prev_valid = 1'b1;
    pc         = 32'h5000_0000;
    step();
    pc = 32'h5000_0004;
    step();
    check_eq("fl.full",    32'(ready_o), 32'd0);
    pc    = 32'h5000_0008;
    flush = 1'b1;
    #1;
    check_eq("fl.readyin", 32'(ready_o), 32'd0);
    step();
    flush      = 1'b0;
    prev_valid = 1'b0;
    check_eq("fl.valid",   32'(valid_o), 32'd0);
    check_eq("fl.ready",   32'(ready_o), 32'd1);
    step();
    check_eq("fl.nolate",  32'(valid_o), 32'd0);
    prev_valid = 1'b1;
    pc         = 32'h5000_0010;
    step();
    prev_valid = 1'b0;
    check_eq("fl.after",   pc_o,         32'h5000_0010);
    next_ready = 1'b1;
    step();
    check_eq("fl.drain",   32'(valid_o), 32'd0);

    // Simultaneous push and pop at occupancy one, across several pointer wraps
    next_ready = 1'b0;
    prev_valid = 1'b1;
    pc         = 32'h6000_0000;
    inst       = 32'h0000_0013;
    step();
    next_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      pc   = 32'h6000_0000 + 32'(k * 4);
      inst = 32'h0000_0013 | (32'(k) << 20);
      step();
      check_eq("pp.valid", 32'(valid_o), 32'd1);
      check_eq("pp.ready", 32'(ready_o), 32'd1);
      check_eq("pp.pc",    pc_o,         32'h6000_0000 + 32'(k * 4));
      check_eq("pp.imm",   imm_o,        32'(k));
    end
    prev_valid = 1'b0;
    step();
    check_eq("pp.empty", 32'(valid_o), 32'd0);

    // Reset mid-operation restores empty queue and zero storage
    next_ready = 1'b0;
    prev_valid = 1'b1;
    pc         = 32'h7000_0000;
    inst       = 32'h0050_0093;
    step();
    pc = 32'h7000_0004;
    step();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    prev_valid = 1'b0;
    check_eq("mr.valid", 32'(valid_o), 32'd0);
    check_eq("mr.ready", 32'(ready_o), 32'd1);
    check_eq("mr.pc",    pc_o,         32'h0);
    check_eq("mr.inst",  inst_o,       32'h0);
    check_eq("mr.fmt",   32'(fmt_o),   32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
